// File: rtl/ray_pkg.sv
// Shared widths, object field slices and scheduler state encoding for the
// ray/sphere scheduling path.
package ray_pkg;

  localparam int INIT_W  = 28;
  localparam int DIR_W   = 31;
  localparam int OBJ_W   = 48;
  localparam int T_W     = 10;
  localparam int COLOR_W = 12;

  localparam logic [T_W-1:0] T_MISS = 10'h3FF;

  // Object word layout: {color12, r8, center28}
  localparam int COLOR_HI  = 47;
  localparam int COLOR_LO  = 36;
  localparam int R_HI      = 35;
  localparam int R_LO      = 28;
  localparam int CENTER_HI = 27;
  localparam int CENTER_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  function automatic logic [COLOR_W-1:0] obj_color(input logic [OBJ_W-1:0] obj);
    return obj[COLOR_HI:COLOR_LO];
  endfunction

endpackage

// File: rtl/ray_sched_tag_pipe.sv
// Tracks which tracer results belong to issued objects, carrying each object's
// colour alongside so it lines up with the matching t value.
module ray_sched_tag_pipe
  import ray_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [COLOR_W-1:0] in_color,
  output logic               out_valid,
  output logic [COLOR_W-1:0] out_color,
  output logic               pipe_busy
);

  // Stage 0 carries only the valid bit: the colour arrives with obj_data one
  // cycle after the read, so it joins the tag at stage 1.
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [COLOR_W-1:0] col_q [1:DEPTH-1];
  logic [COLOR_W-1:0] col_d [1:DEPTH-1];

  always_comb begin
    vld_d    = {vld_q[DEPTH-2:0], in_valid};
    col_d[1] = in_color;
    for (int i = 2; i < DEPTH; i++) begin
      col_d[i] = col_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 1; i < DEPTH; i++) begin
        col_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 1; i < DEPTH; i++) begin
        col_q[i] <= col_d[i];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_color = col_q[DEPTH-1];
  // Busy ignores the output stage: it is consumed in the current cycle.
  assign pipe_busy = |vld_q[DEPTH-2:0];

endmodule

// File: rtl/ray_sphere_scheduler.sv
// Sweeps one ray across every object in scene memory through the sphere tracer
// and returns the nearest hit (smallest t) and its colour.
module ray_sphere_scheduler
  import ray_pkg::*;
#(
  parameter int                 OBJ_AW    = 6,
  parameter int                 TRACE_LAT = 1,
  parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ray_valid,
  output logic               ray_ready,
  input  logic [INIT_W-1:0]  ray_init,
  input  logic [DIR_W-1:0]   ray_dir,
  input  logic [OBJ_AW:0]    num_obj,
  output logic               obj_rd,
  output logic [OBJ_AW-1:0]  obj_addr,
  input  logic [OBJ_W-1:0]   obj_data,
  output logic [INIT_W-1:0]  trc_init,
  output logic [DIR_W-1:0]   trc_dir,
  output logic [OBJ_W-1:0]   trc_object,
  input  logic [T_W-1:0]     trc_t,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [T_W-1:0]     res_t,
  output logic [COLOR_W-1:0] res_color,
  output logic               res_hit,
  output logic               busy
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; the sender holds payload stable until then.

  localparam logic [OBJ_AW:0] MAX_OBJ = {1'b1, {OBJ_AW{1'b0}}};

  sched_state_e state_q, state_d;

  logic [INIT_W-1:0]  init_q, init_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [OBJ_AW:0]    num_q, num_d;
  logic [OBJ_AW-1:0]  addr_q, addr_d;
  logic [T_W-1:0]     best_t_q, best_t_d;
  logic [COLOR_W-1:0] best_color_q, best_color_d;
  logic               hit_q, hit_d;

  logic               accept;
  logic [OBJ_AW:0]    num_sat;
  logic [OBJ_AW:0]    last_idx;
  logic               last_issue;
  logic               tag_valid;
  logic [COLOR_W-1:0] tag_color;
  logic               pipe_busy;

  assign accept     = ray_valid && (state_q == IDLE);
  assign num_sat    = (num_obj > MAX_OBJ) ? MAX_OBJ : num_obj;
  assign last_idx   = num_q - {{OBJ_AW{1'b0}}, 1'b1};
  assign last_issue = ({1'b0, addr_q} == last_idx);

  ray_sched_tag_pipe #(
    .DEPTH (1 + TRACE_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (obj_rd),
    .in_color  (obj_color(obj_data)),
    .out_valid (tag_valid),
    .out_color (tag_color),
    .pipe_busy (pipe_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = (num_obj == '0) ? DONE : ISSUE;
      ISSUE: if (last_issue) state_d = DRAIN;
      DRAIN: if (!pipe_busy) state_d = DONE;
      DONE:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ray_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    obj_rd    = (state_q == ISSUE);
    res_valid = (state_q == DONE);
  end

  always_comb begin
    init_d       = init_q;
    dir_d        = dir_q;
    num_d        = num_q;
    addr_d       = addr_q;
    best_t_d     = best_t_q;
    best_color_d = best_color_q;
    hit_d        = hit_q;
    if (accept) begin
      init_d       = ray_init;
      dir_d        = ray_dir;
      num_d        = num_sat;
      best_t_d     = T_MISS;
      best_color_d = BG_COLOR;
      hit_d        = 1'b0;
      if (num_obj != '0) addr_d = '0;
    end
    if ((state_q == ISSUE) && !last_issue) begin
      addr_d = addr_q + 1'b1;
    end
    // Strict less-than keeps the earlier object on equal t.
    if (tag_valid && (trc_t != T_MISS) && (trc_t < best_t_q)) begin
      best_t_d     = trc_t;
      best_color_d = tag_color;
      hit_d        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q       <= '0;
      dir_q        <= '0;
      num_q        <= '0;
      addr_q       <= '0;
      best_t_q     <= T_MISS;
      best_color_q <= BG_COLOR;
      hit_q        <= 1'b0;
    end else begin
      init_q       <= init_d;
      dir_q        <= dir_d;
      num_q        <= num_d;
      addr_q       <= addr_d;
      best_t_q     <= best_t_d;
      best_color_q <= best_color_d;
      hit_q        <= hit_d;
    end
  end

  assign obj_addr   = addr_q;
  assign trc_init   = init_q;
  assign trc_dir    = dir_q;
  assign trc_object = obj_data;
  assign res_t      = best_t_q;
  assign res_color  = best_color_q;
  assign res_hit    = hit_q;

endmodule

// File: tb/tb_ray_sphere_scheduler.sv
// Directed bench for ray_sphere_scheduler with an object memory and a
// one-cycle tracer model that reads t from the object's low 10 bits.
module tb_ray_sphere_scheduler;

  localparam int OBJ_AW = 6;

  logic        clk;
  logic        rst;
  logic        ray_valid;
  logic        ray_ready;
  logic [27:0] ray_init;
  logic [30:0] ray_dir;
  logic [6:0]  num_obj;
  logic        obj_rd;
  logic [5:0]  obj_addr;
  logic [47:0] obj_data;
  logic [27:0] trc_init;
  logic [30:0] trc_dir;
  logic [47:0] trc_object;
  logic [9:0]  trc_t;
  logic        res_valid;
  logic        res_ready;
  logic [9:0]  res_t;
  logic [11:0] res_color;
  logic        res_hit;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [47:0] mem [64];
  int          rd_cnt = 0;
  logic        rd_prev = 1'b0;
  logic [5:0]  exp_addr = '0;

  ray_sphere_scheduler #(
    .OBJ_AW    (OBJ_AW),
    .TRACE_LAT (1),
    .BG_COLOR  (12'h000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ray_valid  (ray_valid),
    .ray_ready  (ray_ready),
    .ray_init   (ray_init),
    .ray_dir    (ray_dir),
    .num_obj    (num_obj),
    .obj_rd     (obj_rd),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .trc_init   (trc_init),
    .trc_dir    (trc_dir),
    .trc_object (trc_object),
    .trc_t      (trc_t),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_t      (res_t),
    .res_color  (res_color),
    .res_hit    (res_hit),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // object memory (1-cycle read) and tracer model (1-cycle latency)
  always @(posedge clk) begin
    if (obj_rd) obj_data <= mem[obj_addr];
    trc_t <= trc_object[9:0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // address sequence monitor: each burst of reads must walk 0,1,2,...
  always @(negedge clk) begin
    if (obj_rd) begin
      check("obj_addr", {58'd0, obj_addr}, {58'd0, rd_prev ? exp_addr : 6'd0});
      exp_addr <= (rd_prev ? exp_addr : 6'd0) + 6'd1;
      rd_cnt   <= rd_cnt + 1;
    end
    rd_prev <= obj_rd;
  end

  function automatic logic [47:0] mk_obj(input logic [11:0] c, input logic [9:0] t);
    return {c, 8'd5, 18'd0, t};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = mk_obj(12'hFFF, 10'h3FF);
  endtask

  task automatic run_ray(input string name, input logic [6:0] n, input logic [27:0] init,
                         input logic [30:0] dir, input logic [9:0] exp_t,
                         input logic [11:0] exp_c, input logic exp_hit,
                         input int exp_lat, input int exp_rd, input int hold);
    int cyc;
    int rd_start;
    rd_start = rd_cnt;
    @(posedge clk); #1;
    ray_valid = 1'b1; ray_init = init; ray_dir = dir; num_obj = n;
    check({name, "_ready0"}, {63'd0, ray_ready}, 64'd1);
    @(posedge clk); #1;
    ray_valid = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({name, "_t"}, {54'd0, res_t}, {54'd0, exp_t});
    check({name, "_color"}, {52'd0, res_color}, {52'd0, exp_c});
    check({name, "_hit"}, {63'd0, res_hit}, {63'd0, exp_hit});
    check({name, "_init"}, {36'd0, trc_init}, {36'd0, init});
    check({name, "_dir"}, {33'd0, trc_dir}, {33'd0, dir});
    check({name, "_rdcnt"}, 64'(rd_cnt - rd_start), 64'(exp_rd));
    // a competing ray while the result is stalled must not be taken
    for (int i = 0; i < hold; i++) begin
      ray_valid = 1'b1; ray_init = 28'h0ABCDEF; num_obj = 7'd3;
      @(posedge clk); #1;
      check({name, "_hold_valid"}, {63'd0, res_valid}, 64'd1);
      check({name, "_hold_ready"}, {63'd0, ray_ready}, 64'd0);
      check({name, "_hold_t"}, {54'd0, res_t}, {54'd0, exp_t});
      check({name, "_hold_init"}, {36'd0, trc_init}, {36'd0, init});
    end
    ray_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({name, "_idle"}, {62'd0, ray_ready, busy}, 64'b10);
    check({name, "_rv_low"}, {63'd0, res_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; ray_valid = 1'b0; ray_init = '0; ray_dir = '0; num_obj = '0;
    res_ready = 1'b0; obj_data = '0; trc_t = '0;
    clear_mem();
    #1;
    check("rst_ready", {63'd0, ray_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res_t", {54'd0, res_t}, 64'h3FF);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: nearest of three
    mem[0] = mk_obj(12'hA00, 10'd200);
    mem[1] = mk_obj(12'h0B0, 10'd50);
    mem[2] = mk_obj(12'h00C, 10'd300);
    run_ray("t1", 7'd3, 28'h1234567, 31'h12345678, 10'd50, 12'h0B0, 1'b1, 6, 3, 0);

    // 2: all miss
    clear_mem();
    run_ray("t2", 7'd4, 28'h0000111, 31'h00000222, 10'h3FF, 12'h000, 1'b0, 7, 4, 0);

    // 3: tie keeps lower index
    mem[0] = mk_obj(12'h111, 10'd80);
    mem[1] = mk_obj(12'h222, 10'd120);
    mem[2] = mk_obj(12'h333, 10'd80);
    run_ray("t3", 7'd3, 28'h0000333, 31'h00000444, 10'd80, 12'h111, 1'b1, 6, 3, 0);

    // 4: empty scene
    run_ray("t4", 7'd0, 28'h0000555, 31'h00000666, 10'h3FF, 12'h000, 1'b0, 1, 0, 0);

    // 5: downstream stall in DONE
    mem[0] = mk_obj(12'h444, 10'd40);
    run_ray("t5", 7'd1, 28'h0000777, 31'h00000888, 10'd40, 12'h444, 1'b1, 4, 1, 5);

    // saturation: 127 objects clamp to 64, hit only on the last address
    clear_mem();
    mem[63] = mk_obj(12'h777, 10'd7);
    run_ray("sat", 7'd127, 28'h0000999, 31'h00000AAA, 10'd7, 12'h777, 1'b1, 67, 64, 0);

    // 6: reset mid-ray
    clear_mem();
    mem[1] = mk_obj(12'h123, 10'd5);
    @(posedge clk); #1;
    ray_valid = 1'b1; ray_init = 28'h0FEDCBA; ray_dir = 31'h0BADBEEF; num_obj = 7'd8;
    @(posedge clk); #1;
    ray_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_pre_rd", {63'd0, obj_rd}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_rd", {63'd0, obj_rd}, 64'd0);
    check("t6_rst_busy_ready", {62'd0, busy, ray_ready}, 64'b01);
    check("t6_rst_res", {42'd0, res_valid, res_hit, res_t, res_color}, {42'd0, 2'b00, 10'h3FF, 12'h000});
    check("t6_rst_trc", {5'd0, trc_init, trc_dir}, 64'd0);
    check("t6_rst_addr", {58'd0, obj_addr}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    mem[0] = mk_obj(12'h555, 10'd30);
    mem[1] = mk_obj(12'h666, 10'd10);
    run_ray("t6", 7'd2, 28'h0000ABC, 31'h00000DEF, 10'd10, 12'h666, 1'b1, 5, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
